// File: rtl/fetch_control_unit_pkg.sv
// Shared CPU definitions: opcodes, instruction field widths and fetch FSM state codes.
// Used by fetch_control_unit, instruction_decoder and the datapath.
package fetch_control_unit_pkg;

    localparam int unsigned INSTR_WIDTH_DEF    = 16;
    localparam int unsigned OPCODE_LENGTH_DEF  = 5;
    localparam int unsigned OPERAND_LENGTH_DEF = 11;
    localparam int unsigned PC_WIDTH_DEF       = 11;
    localparam int unsigned COUNTER_WIDTH_DEF  = 32;

    localparam logic [4:0] OP_HALT = 5'd0;
    localparam logic [4:0] OP_STO  = 5'd1;
    localparam logic [4:0] OP_LD   = 5'd2;
    localparam logic [4:0] OP_LDI  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_SUBI = 5'd7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    // States in which the cycle counter advances.
    function automatic logic is_running(input logic [2:0] state);
        return (state == ST_FETCH) || (state == ST_LOAD) || (state == ST_EXEC);
    endfunction

endpackage

// File: rtl/fetch_control_unit_pc_register.sv
// Program counter: synchronous clear to zero, increment with natural wrap, otherwise hold.
module pc_register #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_incr,
    output logic [WIDTH-1:0] o_pc
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (i_clear) begin
            pc_d = '0;
        end else if (i_incr) begin
            pc_d = pc_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

// File: rtl/fetch_control_unit.sv
// Fetch/sequencing stage: owns PC and IR, runs FETCH -> LOAD -> EXEC per instruction,
// presents opcode/operand to the decoder and tracks run cycles for debug.
module fetch_control_unit
    import fetch_control_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH       = PC_WIDTH_DEF,
    parameter int unsigned INSTR_WIDTH    = INSTR_WIDTH_DEF,
    parameter int unsigned OPCODE_LENGTH  = OPCODE_LENGTH_DEF,
    parameter int unsigned OPERAND_LENGTH = OPERAND_LENGTH_DEF,
    parameter int unsigned COUNTER_WIDTH  = COUNTER_WIDTH_DEF
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [INSTR_WIDTH-1:0]    i_instruction,
    input  logic                      i_wrPC,
    output logic [PC_WIDTH-1:0]       o_addr_prog,
    output logic                      o_rd_prog,
    output logic [OPCODE_LENGTH-1:0]  o_opcode,
    output logic [OPERAND_LENGTH-1:0] o_operand,
    output logic                      o_exec,
    output logic                      o_halted,
    output logic [PC_WIDTH-1:0]       o_pc,
    output logic [COUNTER_WIDTH-1:0]  o_cycle_count
);

    logic [2:0]               state_q;
    logic [2:0]               state_d;
    logic [INSTR_WIDTH-1:0]   ir_q;
    logic [INSTR_WIDTH-1:0]   ir_d;
    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] count_d;
    logic                     pc_clear;
    logic                     pc_incr;
    logic [PC_WIDTH-1:0]      pc;
    logic                     exec_act;

    pc_register #(
        .WIDTH (PC_WIDTH)
    ) u_pc_register (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (pc_clear),
        .i_incr  (pc_incr),
        .o_pc    (pc)
    );

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        count_d  = count_q;
        pc_clear = 1'b0;
        pc_incr  = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (i_start) begin
                    state_d  = ST_FETCH;
                    pc_clear = 1'b1;
                    count_d  = '0;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                ir_d    = i_instruction;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (i_wrPC) begin
                    pc_incr = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Saturate rather than wrap so long runs never read back as short ones.
        if (is_running(state_q) && (count_q != '1)) begin
            count_d = count_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    // Outputs are masked by reset so they read zero in the very cycle reset is applied.
    assign exec_act      = (state_q == ST_EXEC) && !i_reset;
    assign o_exec        = exec_act;
    assign o_rd_prog     = (state_q == ST_FETCH) && !i_reset;
    assign o_halted      = (state_q == ST_HALTED) && !i_reset;
    assign o_addr_prog   = i_reset ? '0 : pc;
    assign o_pc          = i_reset ? '0 : pc;
    assign o_cycle_count = i_reset ? '0 : count_q;
    assign o_opcode      = exec_act ? ir_q[INSTR_WIDTH-1 -: OPCODE_LENGTH] : '0;
    assign o_operand     = exec_act ? ir_q[OPERAND_LENGTH-1:0] : '0;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed bench for fetch_control_unit with a 1-cycle program memory and a decoder stand-in.
module tb_fetch_control_unit;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_instruction;
    logic        i_wrPC;
    logic [10:0] o_addr_prog;
    logic        o_rd_prog;
    logic [4:0]  o_opcode;
    logic [10:0] o_operand;
    logic        o_exec;
    logic        o_halted;
    logic [10:0] o_pc;
    logic [31:0] o_cycle_count;

    logic [10:0] sat_addr;
    logic        sat_rd;
    logic [4:0]  sat_opcode;
    logic [10:0] sat_operand;
    logic        sat_exec;
    logic        sat_halted;
    logic [10:0] sat_pc;
    logic [3:0]  sat_count;

    logic [15:0] mem [0:2047];
    logic [15:0] rd_data = '0;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned exec_cnt = 0;
    int unsigned idle_bad = 0;
    logic [4:0]  opc_log [0:15];
    logic [10:0] opd_log [0:15];

    always #5 clk = ~clk;

    fetch_control_unit #(
        .PC_WIDTH (11), .INSTR_WIDTH (16), .OPCODE_LENGTH (5),
        .OPERAND_LENGTH (11), .COUNTER_WIDTH (32)
    ) dut (
        .i_clock (clk), .i_reset (i_reset), .i_start (i_start),
        .i_instruction (i_instruction), .i_wrPC (i_wrPC),
        .o_addr_prog (o_addr_prog), .o_rd_prog (o_rd_prog),
        .o_opcode (o_opcode), .o_operand (o_operand), .o_exec (o_exec),
        .o_halted (o_halted), .o_pc (o_pc), .o_cycle_count (o_cycle_count)
    );

    // Narrow counter copy runs in lockstep to exercise saturation.
    fetch_control_unit #(
        .PC_WIDTH (11), .INSTR_WIDTH (16), .OPCODE_LENGTH (5),
        .OPERAND_LENGTH (11), .COUNTER_WIDTH (4)
    ) dut_sat (
        .i_clock (clk), .i_reset (i_reset), .i_start (i_start),
        .i_instruction (i_instruction), .i_wrPC (i_wrPC),
        .o_addr_prog (sat_addr), .o_rd_prog (sat_rd),
        .o_opcode (sat_opcode), .o_operand (sat_operand), .o_exec (sat_exec),
        .o_halted (sat_halted), .o_pc (sat_pc), .o_cycle_count (sat_count)
    );

    always @(posedge clk) begin
        if (o_rd_prog) rd_data <= mem[o_addr_prog];
    end
    assign i_instruction = rd_data;
    assign i_wrPC = (o_opcode >= 5'd1) && (o_opcode <= 5'd7);

    always @(negedge clk) begin
        if (o_exec) begin
            opc_log[exec_cnt[3:0]] = o_opcode;
            opd_log[exec_cnt[3:0]] = o_operand;
            exec_cnt = exec_cnt + 1;
        end else if ((o_opcode != 5'd0) || (o_operand != 11'd0)) begin
            idle_bad = idle_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_start = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_to_halt(input int unsigned budget);
        int unsigned n = 0;
        while (!o_halted && (n < budget)) begin
            tick();
            n = n + 1;
        end
        check("halt_reached", o_halted, 1);
    endtask

    task automatic clear_mem(input logic [15:0] fill);
        for (int i = 0; i < 2048; i++) mem[i] = fill;
    endtask

    int unsigned base;

    initial begin
        clear_mem(16'h0000);
        tick();
        // Reset state: outputs zero while reset held.
        check("rst_rd", o_rd_prog, 0);
        check("rst_exec", o_exec, 0);
        check("rst_halted", o_halted, 0);
        check("rst_pc", o_pc, 0);
        check("rst_count", o_cycle_count, 0);
        do_reset();
        check("idle_rd", o_rd_prog, 0);
        check("idle_pc", o_pc, 0);

        // Test 1: LDI 5, ADDI 3, HALT.
        mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0000;
        base = exec_cnt;
        pulse_start();
        check("t1_fetch_rd", o_rd_prog, 1);
        check("t1_fetch_addr", o_addr_prog, 0);
        check("t1_fetch_count", o_cycle_count, 0);
        run_to_halt(40);
        check("t1_exec_pulses", exec_cnt - base, 3);
        check("t1_opc0", opc_log[(base + 0) & 15], 3);
        check("t1_opd0", opd_log[(base + 0) & 15], 5);
        check("t1_opc1", opc_log[(base + 1) & 15], 5);
        check("t1_opd1", opd_log[(base + 1) & 15], 3);
        check("t1_opc2", opc_log[(base + 2) & 15], 0);
        check("t1_opd2", opd_log[(base + 2) & 15], 0);
        check("t1_pc", o_pc, 2);
        check("t1_count", o_cycle_count, 9);
        check("t1_sat_count", sat_count, 9);
        check("t1_sat_halted", sat_halted, 1);
        tick();
        check("t1_frozen_pc", o_pc, 2);
        check("t1_frozen_count", o_cycle_count, 9);

        // Test 2: reset during LOAD of the second instruction.
        do_reset();
        pulse_start();
        tick(); tick(); tick(); tick();
        check("t2_pc_before", o_pc, 1);
        check("t2_count_before", o_cycle_count, 4);
        i_reset = 1'b1;
        #1;
        base = exec_cnt;
        check("t2_rst_pc", o_pc, 0);
        check("t2_rst_count", o_cycle_count, 0);
        check("t2_rst_exec", o_exec, 0);
        tick();
        i_reset = 1'b0;
        #1;
        check("t2_after_pc", o_pc, 0);
        check("t2_after_count", o_cycle_count, 0);
        check("t2_after_rd", o_rd_prog, 0);
        for (int i = 0; i < 5; i++) tick();
        check("t2_no_exec", exec_cnt - base, 0);
        check("t2_still_idle", {o_rd_prog, o_halted, o_exec}, 0);

        // Test 3: undefined opcode 0x1F at address 0.
        clear_mem(16'h0000);
        mem[0] = 16'hF800;
        do_reset();
        base = exec_cnt;
        pulse_start();
        run_to_halt(20);
        check("t3_pc", o_pc, 0);
        check("t3_count", o_cycle_count, 3);
        check("t3_opc", opc_log[base & 15], 31);
        check("t3_pulses", exec_cnt - base, 1);

        // Test 4: i_start toggling while running, then restart from HALTED.
        clear_mem(16'h0000);
        mem[0] = 16'h2801; mem[1] = 16'h2802; mem[2] = 16'h2803;
        do_reset();
        base = exec_cnt;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            i_start = (i % 2 == 0);
            tick();
        end
        i_start = 1'b0;
        check("t4_mid_pc", o_pc, 2);
        check("t4_mid_count", o_cycle_count, 6);
        run_to_halt(40);
        check("t4_pc", o_pc, 3);
        check("t4_count", o_cycle_count, 12);
        check("t4_pulses", exec_cnt - base, 4);
        pulse_start();
        check("t4_restart_pc", o_pc, 0);
        check("t4_restart_count", o_cycle_count, 0);
        check("t4_restart_rd", o_rd_prog, 1);
        check("t4_restart_halted", o_halted, 0);
        run_to_halt(40);
        check("t4_rerun_count", o_cycle_count, 12);

        // Test 5: 2048 ADDI words, PC wraps and execution continues.
        clear_mem(16'h2801);
        do_reset();
        pulse_start();
        for (int i = 0; i < 3 * 2047; i++) tick();
        check("t5_last_addr", o_addr_prog, 2047);
        check("t5_last_rd", o_rd_prog, 1);
        tick(); tick();
        check("t5_last_exec", o_exec, 1);
        check("t5_last_opc", o_opcode, 5);
        tick();
        check("t5_wrap_addr", o_addr_prog, 0);
        check("t5_wrap_rd", o_rd_prog, 1);
        check("t5_wrap_count", o_cycle_count, 6144);
        check("t5_sat_count", sat_count, 15);
        check("t5_sat_pc", sat_pc, 0);
        tick(); tick(); tick();
        check("t5_cont_addr", o_addr_prog, 1);
        check("t5_cont_halted", o_halted, 0);

        check("idle_fields_zero", idle_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
